operand_entry_controller: RTL and testbench
===========================================

# operand_entry_controller

Captures the two 4-bit operands for the adder/seven-segment datapath from the board's slide switches under push-button control. Raw buttons and switches are synchronised to `clock_100MHz` and the buttons are debounced. A small FSM latches operand A, then operand B. The registered `A`/`B` outputs drive the adder inputs directly. `operands_valid` marks when both operands are loaded.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive synchronised cycles a button must hold a new level before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- `clock_100MHz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `sw`  in  4  raw slide switches; operand value.
- `btn_load`  in  1  raw load button, active-high, bouncy.
- `btn_clear`  in  1  raw clear button, active-high, bouncy.
- `A`  out  4  operand A, registered.
- `B`  out  4  operand B, registered.
- `operands_valid`  out  1  high when A and B have both been loaded since the last clear or reload.
- `state`  out  2  FSM state, for LEDs: 00 WAIT_A, 01 WAIT_B, 10 READY.
- `load_pulse`  out  1  one-cycle registered strobe per accepted load press.

## Operation
- **Synchronisers**
  - `sw`, `btn_load` and `btn_clear` each pass through a 2-FF synchroniser.
  - Captured operand values always come from the synchronised `sw`.
- **Debouncers** (one per button)
  - Each holds a `stable` level and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears on any cycle where the synchronised input equals `stable`.
  - Otherwise the counter increments.
  - When it would reach DEBOUNCE_CYCLES, `stable` toggles and the counter clears.
  - A run of differing samples shorter than DEBOUNCE_CYCLES produces no change.
- **Edge detect**
  - A registered pulse fires for one cycle on each 0→1 transition of `stable`.
  - Release (1→0) produces no pulse.
  - A held button yields exactly one pulse.
- **FSM** (acts on the pulses)
  - WAIT_A + load: `A`←sw; go to WAIT_B.
  - WAIT_B + load: `B`←sw; `operands_valid`←1; go to READY.
  - READY + load: `A`←sw; `B` holds; `operands_valid`←0; go to WAIT_B.
  - Any state + clear: `A`←0, `B`←0, `operands_valid`←0; go to WAIT_A.
  - Clear and load pulses in the same cycle: clear wins, load is discarded.
  - Unused encoding 11: go to WAIT_A with the clear actions.
- No arithmetic is done on operands; they are stored verbatim (unsigned 4-bit, any value 0–15).

## Timing
- **Reset values**
  - `A`=0, `B`=0, `operands_valid`=0, `state`=00, `load_pulse`=0.
  - All synchroniser flops, `stable` levels and counters are 0.
- **Button latency**, with D = DEBOUNCE_CYCLES and a raw button high from just before edge 1 and held steady:
  - Synchronised value is high after edge 2.
  - `stable` rises at edge D+2.
  - `load_pulse` is high for the cycle following edge D+3.
  - `A`/`B`/`state`/`operands_valid` update at edge D+4.
- **Operand sampling:** the value captured is synchronised `sw` at edge D+4, i.e. raw `sw` as of 2 edges earlier. `sw` must be stable for ≥ 3 cycles before that edge.
- **Release:** a release requires D stable-low cycles before the next press can be detected.
- **Reset mid-debounce:** the counter is lost and no pulse is produced. A button still held when reset deasserts is treated as a fresh press, and pulses D+3 edges after release of reset.
- **Outputs:** `A`, `B`, `operands_valid` and `state` are glitch-free register outputs. The downstream adder sees new values one cycle after the `load_pulse` cycle.

## Test plan
(Bench uses DEBOUNCE_CYCLES=4.)
- **Reset:** assert `reset` mid-run with `A`=5, `B`=6 → all outputs 0 and `state`=00 asynchronously, held through deassert.
- **Basic load:** sw=4'h7, btn_load high 20 cycles then low 20; then sw=4'h9, repeat.
  - Required: `A`=7, `B`=9, `operands_valid`=1, `state`=10.
  - Exactly two `load_pulse` strobes, each at edge 7 relative to the press.
- **Bounce:** btn_load toggles high 3 cycles / low 2 cycles ×5, then steady high 10 → exactly one `load_pulse`, after the steady segment only. A 3-cycle glitch alone → no pulse, state unchanged.
- **Reload from READY:** sw=4'h3, press load → `A`=3, `B`=9 held, `operands_valid`=0, `state`=01.
- **Clear and priority:**
  - From READY, press clear → `A`=0, `B`=0, `operands_valid`=0, `state`=00.
  - Drive btn_load and btn_clear identically so both pulses coincide → clear result, `A` not loaded.
- **Reset mid-debounce:** assert reset 2 cycles into a load press and release it while the button is still held → no pulse during reset; one pulse D+3 edges after deassert; `A`=sw.

Source files
------------

// File: rtl/operand_entry_controller.sv
// rtl/operand_entry_controller.sv - switch/button operand capture for the adder datapath
module operand_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock_100MHz,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       operands_valid,
  output logic [1:0] state,
  output logic       load_pulse
);

  // Counter wide enough to hold DEBOUNCE_CYCLES; the toggle happens on the
  // cycle the count would reach it, so the last stored value is D-1.
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_WAIT_A = 2'b00;
  localparam logic [1:0] ST_WAIT_B = 2'b01;
  localparam logic [1:0] ST_READY  = 2'b10;

  // Bit positions in the per-button vectors.
  localparam int BTN_LOAD  = 0;
  localparam int BTN_CLEAR = 1;

  logic [3:0]    sw_meta_q, sw_meta_d;
  logic [3:0]    sw_sync_q, sw_sync_d;
  logic [1:0]    btn_meta_q, btn_meta_d;
  logic [1:0]    btn_sync_q, btn_sync_d;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    stable_prev_q, stable_prev_d;
  logic [1:0]    pulse_q, pulse_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic          valid_q, valid_d;
  logic [1:0]    state_q, state_d;

  // Two-stage synchronisers for the switches and both buttons.
  always_comb begin
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = {btn_clear, btn_load};
    btn_sync_d = btn_meta_q;
  end

  // Debounce: count consecutive samples that disagree with the accepted level
  // and flip the level once the disagreement has lasted DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    cnt_d[0] = '0;
    cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (btn_sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising-edge detect on the debounced levels; releases give no pulse.
  always_comb begin
    stable_prev_d = stable_q;
    pulse_d       = stable_q & ~stable_prev_q;
  end

  // Operand FSM: clear always beats load; encoding 11 recovers like a clear.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    state_d = state_q;
    if (pulse_q[BTN_CLEAR] || (state_q == 2'b11)) begin
      a_d     = 4'h0;
      b_d     = 4'h0;
      valid_d = 1'b0;
      state_d = ST_WAIT_A;
    end else if (pulse_q[BTN_LOAD]) begin
      case (state_q)
        ST_WAIT_A: begin
          a_d     = sw_sync_q;
          state_d = ST_WAIT_B;
        end
        ST_WAIT_B: begin
          b_d     = sw_sync_q;
          valid_d = 1'b1;
          state_d = ST_READY;
        end
        ST_READY: begin
          a_d     = sw_sync_q;
          valid_d = 1'b0;
          state_d = ST_WAIT_B;
        end
        default: begin
          a_d     = 4'h0;
          b_d     = 4'h0;
          valid_d = 1'b0;
          state_d = ST_WAIT_A;
        end
      endcase
    end
  end

  // State registers; everything returns to zero on the asynchronous reset.
  always_ff @(posedge clock_100MHz or posedge reset) begin
    if (reset) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      btn_meta_q    <= '0;
      btn_sync_q    <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      pulse_q       <= '0;
      cnt_q[0]      <= '0;
      cnt_q[1]      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      valid_q       <= 1'b0;
      state_q       <= ST_WAIT_A;
    end else begin
      sw_meta_q     <= sw_meta_d;
      sw_sync_q     <= sw_sync_d;
      btn_meta_q    <= btn_meta_d;
      btn_sync_q    <= btn_sync_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      pulse_q       <= pulse_d;
      cnt_q[0]      <= cnt_d[0];
      cnt_q[1]      <= cnt_d[1];
      a_q           <= a_d;
      b_q           <= b_d;
      valid_q       <= valid_d;
      state_q       <= state_d;
    end
  end

  assign A              = a_q;
  assign B              = b_q;
  assign operands_valid = valid_q;
  assign state          = state_q;
  assign load_pulse     = pulse_q[BTN_LOAD];

endmodule

// File: tb/tb_operand_entry_controller.sv
// tb/tb_operand_entry_controller.sv - self-checking bench for operand_entry_controller
module tb_operand_entry_controller;

  localparam int D = 4;

  logic       clock_100MHz;
  logic       reset;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] A;
  logic [3:0] B;
  logic       operands_valid;
  logic [1:0] state;
  logic       load_pulse;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  operand_entry_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clock_100MHz  (clock_100MHz),
    .reset         (reset),
    .sw            (sw),
    .btn_load      (btn_load),
    .btn_clear     (btn_clear),
    .A             (A),
    .B             (B),
    .operands_valid(operands_valid),
    .state         (state),
    .load_pulse    (load_pulse)
  );

  initial begin
    clock_100MHz = 1'b0;
    forever #5 clock_100MHz = ~clock_100MHz;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: raw input histories per clock edge. A button's accepted
  // level flips when the last D synchronised samples (raw taken two edges
  // earlier) all disagree with it. A flip to 1 shows as a strobe one edge
  // later, and the FSM acts on the strobe at the edge after that.
  bit         ql[$];
  bit         qc[$];
  logic [3:0] qs[$];
  bit         m_sl, m_sc, m_rl, m_rc, m_lp, m_cp, m_v;
  logic [3:0] m_a, m_b;
  int         m_s;

  function automatic bit all_differ(input bit q[$], input bit lvl);
    for (int i = 2; i <= D + 1; i++) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    ql = {}; qc = {}; qs = {};
    for (int i = 0; i < D + 2; i++) begin
      ql.push_back(1'b0); qc.push_back(1'b0); qs.push_back(4'h0);
    end
    m_sl = 0; m_sc = 0; m_rl = 0; m_rc = 0; m_lp = 0; m_cp = 0;
    m_a = 0; m_b = 0; m_v = 0; m_s = 0;
  endtask

  task automatic model_edge();
    ql.push_front(btn_load);  void'(ql.pop_back());
    qc.push_front(btn_clear); void'(qc.pop_back());
    qs.push_front(sw);        void'(qs.pop_back());
    if (m_cp) begin
      m_a = 0; m_b = 0; m_v = 0; m_s = 0;
    end else if (m_lp) begin
      if (m_s == 0)      begin m_a = qs[2]; m_s = 1; end
      else if (m_s == 1) begin m_b = qs[2]; m_v = 1; m_s = 2; end
      else               begin m_a = qs[2]; m_v = 0; m_s = 1; end
    end
    m_lp = m_rl;
    m_cp = m_rc;
    m_rl = 0;
    m_rc = 0;
    if (all_differ(ql, m_sl)) begin m_sl = !m_sl; m_rl = m_sl; end
    if (all_differ(qc, m_sc)) begin m_sc = !m_sc; m_rc = m_sc; end
  endtask

  always @(posedge clock_100MHz or posedge reset) begin
    if (reset) model_reset();
    else       model_edge();
  end

  always @(negedge clock_100MHz) begin
    if (chk_en) begin
      chk("model_A", int'(A), int'(m_a));
      chk("model_B", int'(B), int'(m_b));
      chk("model_valid", int'(operands_valid), int'(m_v));
      chk("model_state", int'(state), m_s);
      chk("model_load_pulse", int'(load_pulse), int'(m_lp));
    end
  end

  typedef struct {
    bit         ld;
    bit         cl;
    logic [3:0] swv;
    int         hold;
    int         exp_np;
    int         exp_edge;
    logic [3:0] ea;
    logic [3:0] eb;
    bit         ev;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[10];

  // Drive one press for `hold` cycles inside a 40-cycle window; report
  // the number of load strobes and the edge index of the first one.
  task automatic press(input bit ld, input bit cl, input logic [3:0] s,
                       input int hold, output int np, output int first);
    np = 0; first = 0;
    sw = s;
    for (int c = 1; c <= 40; c++) begin
      btn_load  = ld && (c <= hold);
      btn_clear = cl && (c <= hold);
      @(posedge clock_100MHz);
      @(negedge clock_100MHz);
      if (load_pulse) begin
        np++;
        if (first == 0) first = c;
      end
    end
    btn_load = 0; btn_clear = 0;
  endtask

  initial begin
    int np, first;
    int rl, rc;
    bit lv, cv;

    vecs[0] = '{1, 0, 4'h7, 20, 1, 7, 4'h7, 4'h0, 0, 2'b01};
    vecs[1] = '{1, 0, 4'h9, 20, 1, 7, 4'h7, 4'h9, 1, 2'b10};
    vecs[2] = '{1, 0, 4'h3, 20, 1, 7, 4'h3, 4'h9, 0, 2'b01};
    vecs[3] = '{1, 0, 4'h9, 20, 1, 7, 4'h3, 4'h9, 1, 2'b10};
    vecs[4] = '{0, 1, 4'hF, 20, 0, 0, 4'h0, 4'h0, 0, 2'b00};
    vecs[5] = '{1, 0, 4'h8, 20, 1, 7, 4'h8, 4'h0, 0, 2'b01};
    vecs[6] = '{1, 1, 4'h5, 20, 1, 7, 4'h0, 4'h0, 0, 2'b00};
    vecs[7] = '{1, 0, 4'h2,  3, 0, 0, 4'h0, 4'h0, 0, 2'b00};
    vecs[8] = '{1, 0, 4'h5, 20, 1, 7, 4'h5, 4'h0, 0, 2'b01};
    vecs[9] = '{1, 0, 4'h6, 20, 1, 7, 4'h5, 4'h6, 1, 2'b10};

    sw = 0; btn_load = 0; btn_clear = 0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock_100MHz);
    chk("rst_A", int'(A), 0);
    chk("rst_B", int'(B), 0);
    chk("rst_valid", int'(operands_valid), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_load_pulse", int'(load_pulse), 0);
    chk_en = 1;
    #2 reset = 1'b0;
    @(negedge clock_100MHz);

    for (int i = 0; i < 10; i++) begin
      press(vecs[i].ld, vecs[i].cl, vecs[i].swv, vecs[i].hold, np, first);
      chk($sformatf("vec%0d_pulses", i), np, vecs[i].exp_np);
      chk($sformatf("vec%0d_edge", i), first, vecs[i].exp_edge);
      chk($sformatf("vec%0d_A", i), int'(A), int'(vecs[i].ea));
      chk($sformatf("vec%0d_B", i), int'(B), int'(vecs[i].eb));
      chk($sformatf("vec%0d_valid", i), int'(operands_valid), int'(vecs[i].ev));
      chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].es));
    end

    // Asynchronous reset mid-run with A=5, B=6 loaded.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_A", int'(A), 0);
    chk("async_rst_B", int'(B), 0);
    chk("async_rst_valid", int'(operands_valid), 0);
    chk("async_rst_state", int'(state), 0);
    repeat (2) @(negedge clock_100MHz);
    #2 reset = 1'b0;
    @(negedge clock_100MHz);
    chk("post_rst_A", int'(A), 0);
    chk("post_rst_state", int'(state), 0);

    // Bounce: 5 x (high 3, low 2) then steady high 10, then low.
    sw = 4'hA; np = 0; first = 0;
    for (int c = 1; c <= 55; c++) begin
      if (c <= 25) btn_load = (((c - 1) % 5) < 3);
      else         btn_load = (c <= 35);
      @(posedge clock_100MHz);
      @(negedge clock_100MHz);
      if (load_pulse) begin
        np++;
        if (first == 0) first = c;
      end
    end
    chk("bounce_pulses", np, 1);
    chk("bounce_edge", first, 32);
    chk("bounce_A", int'(A), 10);
    chk("bounce_state", int'(state), 1);

    // Reset two cycles into a press, released while the button is held.
    sw = 4'hC; btn_load = 1'b1; np = 0; first = 0;
    repeat (2) @(posedge clock_100MHz);
    @(negedge clock_100MHz);
    #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clock_100MHz);
      chk("rst_hold_no_pulse", int'(load_pulse), 0);
    end
    #2 reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock_100MHz);
      @(negedge clock_100MHz);
      if (load_pulse) begin
        np++;
        if (first == 0) first = e;
      end
    end
    btn_load = 1'b0;
    repeat (20) @(negedge clock_100MHz);
    chk("rst_press_pulses", np, 1);
    chk("rst_press_edge", first, D + 3);
    chk("rst_press_A", int'(A), 12);
    chk("rst_press_B", int'(B), 0);
    chk("rst_press_state", int'(state), 1);

    // Randomised button runs and switch changes against the model.
    rl = 0; rc = 0; lv = 0; cv = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rl == 0) begin
        lv = 1'($urandom_range(0, 1));
        rl = $urandom_range(1, 2 * D + 4);
      end
      if (rc == 0) begin
        cv = ($urandom_range(0, 3) == 0);
        rc = $urandom_range(1, 2 * D + 4);
      end
      rl--; rc--;
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
      btn_load  = lv;
      btn_clear = cv;
      @(posedge clock_100MHz);
      @(negedge clock_100MHz);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
